// File: rtl/md4_round_sequencer_pkg.sv
// Shared constants, tables, state type and MD4 boolean functions for the
// iterative MD4 round sequencer.
package md4_round_sequencer_pkg;

  // Default chaining initial values (MD4 IV)
  localparam logic [31:0] IV_A_INIT = 32'h67452301;
  localparam logic [31:0] IV_B_INIT = 32'hEFCDAB89;
  localparam logic [31:0] IV_C_INIT = 32'h98BADCFE;
  localparam logic [31:0] IV_D_INIT = 32'h10325476;

  // Per-round additive constants
  localparam logic [31:0] K_R0 = 32'h00000000;
  localparam logic [31:0] K_R1 = 32'h5A827999;
  localparam logic [31:0] K_R2 = 32'h6ED9EBA1;

  // Index of the final step of a block (3 rounds x 16 steps)
  localparam logic [5:0] LAST_STEP = 6'd47;

  // Rotate amounts, selected by step[1:0]
  localparam logic [4:0] S_R0 [4] = '{5'd3, 5'd7, 5'd11, 5'd19};
  localparam logic [4:0] S_R1 [4] = '{5'd3, 5'd5, 5'd9, 5'd13};
  localparam logic [4:0] S_R2 [4] = '{5'd3, 5'd9, 5'd11, 5'd15};

  // Message word selected at each step within a round
  localparam logic [3:0] K_IDX_R0 [16] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                                           4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
  localparam logic [3:0] K_IDX_R1 [16] = '{4'd0, 4'd4, 4'd8, 4'd12, 4'd1, 4'd5, 4'd9, 4'd13,
                                           4'd2, 4'd6, 4'd10, 4'd14, 4'd3, 4'd7, 4'd11, 4'd15};
  localparam logic [3:0] K_IDX_R2 [16] = '{4'd0, 4'd8, 4'd4, 4'd12, 4'd2, 4'd10, 4'd6, 4'd14,
                                           4'd1, 4'd9, 4'd5, 4'd13, 4'd3, 4'd11, 4'd7, 4'd15};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2
  } state_t;

  // Round 0 selection function
  function automatic logic [31:0] md4_f(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
    md4_f = (x & y) | (~x & z);
  endfunction

  // Round 1 majority function
  function automatic logic [31:0] md4_g(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
    md4_g = (x & y) | (x & z) | (y & z);
  endfunction

  // Round 2 parity function
  function automatic logic [31:0] md4_h(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
    md4_h = x ^ y ^ z;
  endfunction

  // 32-bit rotate left; s is never 0 in MD4 but the expression stays safe for it
  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] s);
    rotl32 = (x << s) | (x >> (6'd32 - {1'b0, s}));
  endfunction

endpackage

// File: rtl/md4_round_sequencer_step.sv
// Combinational single MD4 step, shared by all 48 steps of a block:
// result = rotl(a + fn_round(b,c,d) + x + k, s).
module md4_step
  import md4_round_sequencer_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  logic [31:0] x,
  input  logic [31:0] k,
  input  logic [4:0]  s,
  input  logic [1:0]  round,
  output logic [31:0] result
);

  logic [31:0] fval;
  logic [31:0] sum;

  // Pick the round's boolean function and form the wrapped 32-bit sum
  always_comb begin
    fval = 32'h0;
    case (round)
      2'd0:    fval = md4_f(b, c, d);
      2'd1:    fval = md4_g(b, c, d);
      default: fval = md4_h(b, c, d);
    endcase
    sum = a + fval + x + k;
  end

  assign result = rotl32(sum, s);

endmodule

// File: rtl/md4_round_sequencer.sv
// Iterative MD4 compression controller: accepts one 512-bit padded block at a
// time, runs 48 steps through a single shared step datapath, folds the result
// into the chaining registers and emits the digest after a block flagged last.
// Handshake: a block is taken on a rising edge where blk_valid and blk_ready
// are both high; blk_ready is high only in IDLE and blk_data/blk_last are
// latched at that edge, so the source may change or drop them afterwards.
module md4_round_sequencer
  import md4_round_sequencer_pkg::*;
#(
  parameter logic [31:0] IV_A = IV_A_INIT,
  parameter logic [31:0] IV_B = IV_B_INIT,
  parameter logic [31:0] IV_C = IV_C_INIT,
  parameter logic [31:0] IV_D = IV_D_INIT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         init,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_last,
  output logic         busy,
  output logic         digest_valid,
  output logic [127:0] digest
);

  state_t       state;
  logic [5:0]   step;
  logic [511:0] blk;
  logic         last_q;

  // Working registers (updated every step) and chaining registers
  logic [31:0] wa, wb, wc, wd;
  logic [31:0] ca, cb, cc, cd;

  logic [1:0]  round;
  logic [3:0]  word_idx;
  logic [4:0]  shift;
  logic [31:0] kconst;
  logic [31:0] x_word;
  logic [31:0] step_new;
  logic [31:0] sum_a, sum_b, sum_c, sum_d;

  assign round = step[5:4];

  // Decode the current step into message word, rotate amount and constant
  always_comb begin
    word_idx = 4'd0;
    shift    = 5'd0;
    kconst   = 32'h0;
    case (round)
      2'd0: begin
        word_idx = K_IDX_R0[step[3:0]];
        shift    = S_R0[step[1:0]];
        kconst   = K_R0;
      end
      2'd1: begin
        word_idx = K_IDX_R1[step[3:0]];
        shift    = S_R1[step[1:0]];
        kconst   = K_R1;
      end
      default: begin
        word_idx = K_IDX_R2[step[3:0]];
        shift    = S_R2[step[1:0]];
        kconst   = K_R2;
      end
    endcase
    x_word = blk[32*word_idx +: 32];
  end

  md4_step u_step (
    .a      (wa),
    .b      (wb),
    .c      (wc),
    .d      (wd),
    .x      (x_word),
    .k      (kconst),
    .s      (shift),
    .round  (round),
    .result (step_new)
  );

  // Per-word feed-forward of the block result into the chain
  assign sum_a = ca + wa;
  assign sum_b = cb + wb;
  assign sum_c = cc + wc;
  assign sum_d = cd + wd;

  assign blk_ready = (state == ST_IDLE);
  assign busy      = ~blk_ready;

  // Sequencer FSM: accept block, run 48 steps, fold into chain, report digest
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      step         <= 6'd0;
      blk          <= '0;
      last_q       <= 1'b0;
      wa           <= 32'h0;
      wb           <= 32'h0;
      wc           <= 32'h0;
      wd           <= 32'h0;
      ca           <= IV_A;
      cb           <= IV_B;
      cc           <= IV_C;
      cd           <= IV_D;
      digest_valid <= 1'b0;
      digest       <= '0;
    end else begin
      digest_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (init) begin
            ca <= IV_A;
            cb <= IV_B;
            cc <= IV_C;
            cd <= IV_D;
          end
          if (blk_valid) begin
            blk    <= blk_data;
            last_q <= blk_last;
            step   <= 6'd0;
            state  <= ST_ROUND;
            // A same-cycle init means the block belongs to a new message
            if (init) begin
              wa <= IV_A;
              wb <= IV_B;
              wc <= IV_C;
              wd <= IV_D;
            end else begin
              wa <= ca;
              wb <= cb;
              wc <= cc;
              wd <= cd;
            end
          end
        end
        ST_ROUND: begin
          wa <= wd;
          wb <= step_new;
          wc <= wb;
          wd <= wc;
          if (step == LAST_STEP) begin
            step  <= 6'd0;
            state <= ST_FINAL;
          end else begin
            step <= step + 6'd1;
          end
        end
        ST_FINAL: begin
          ca <= sum_a;
          cb <= sum_b;
          cc <= sum_c;
          cd <= sum_d;
          if (last_q) begin
            digest       <= {sum_d, sum_c, sum_b, sum_a};
            digest_valid <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md4_round_sequencer.sv
// Bench for md4_round_sequencer: table of single-block messages plus
// hand-written multi-cycle sequences, checked against an MD4 reference model.
// Cycle counting: the negedge where the handshake is presented is cycle N;
// the block result is expected at the 50th negedge after it.
module tb_md4_round_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         init;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_last;
  logic         busy;
  logic         digest_valid;
  logic [127:0] digest;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] IV_CHAIN =
    {32'h10325476, 32'h98BADCFE, 32'hEFCDAB89, 32'h67452301};
  localparam logic [127:0] DG_EMPTY = 128'hc089c0e0_d7593cb7_31e96ad1_e0cfd631;
  localparam logic [127:0] DG_ABC   = 128'h9d72a67a_e80ac15f_52d821af_7a0148a4;

  typedef struct {
    logic [511:0] data;
    logic [127:0] exp;
  } vec_t;

  vec_t vec[6];

  md4_round_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .init         (init),
    .blk_valid    (blk_valid),
    .blk_ready    (blk_ready),
    .blk_data     (blk_data),
    .blk_last     (blk_last),
    .busy         (busy),
    .digest_valid (digest_valid),
    .digest       (digest)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference MD4 compression of one block, chain packed as {D,C,B,A}
  function automatic logic [127:0] md4_model(input logic [127:0] chain, input logic [511:0] blk);
    logic [31:0] v[4];
    logic [31:0] h[4];
    logic [31:0] x[16];
    logic [31:0] kc[3];
    int          sh[3][4];
    logic [31:0] f, t, nw, tmp;
    logic [3:0]  ii;
    int          k, s;
    kc = '{32'h0, 32'h5A827999, 32'h6ED9EBA1};
    sh = '{'{3, 7, 11, 19}, '{3, 5, 9, 13}, '{3, 9, 11, 15}};
    for (int i = 0; i < 16; i++) x[i] = blk[32*i +: 32];
    for (int i = 0; i < 4; i++) begin
      h[i] = chain[32*i +: 32];
      v[i] = h[i];
    end
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) begin
        ii = i[3:0];
        if (r == 0) begin
          k = i;
          f = (v[1] & v[2]) | (~v[1] & v[3]);
        end else if (r == 1) begin
          k = (i % 4) * 4 + i / 4;
          f = (v[1] & v[2]) | (v[1] & v[3]) | (v[2] & v[3]);
        end else begin
          k = int'({ii[0], ii[1], ii[2], ii[3]});
          f = v[1] ^ v[2] ^ v[3];
        end
        t  = v[0] + f + x[k] + kc[r];
        s  = sh[r][i % 4];
        nw = (t << s) | (t >> (32 - s));
        tmp  = v[3];
        v[3] = v[2];
        v[2] = v[1];
        v[1] = nw;
        v[0] = tmp;
      end
    end
    return {h[3] + v[3], h[2] + v[2], h[1] + v[1], h[0] + v[0]};
  endfunction

  function automatic logic [511:0] rand_blk();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Present one block, then watch until blk_ready returns (bounded).
  // init_step >= 0 pulses init while that step is in flight; scramble
  // replaces blk_data with random words every busy cycle.
  task automatic run_block(input logic [511:0] data, input logic last, input logic with_init,
                           input int init_step, input bit scramble,
                           output int lat, output int dv_count, output int busy_bad,
                           output logic [127:0] dg);
    int cnt;
    lat      = -1;
    dv_count = 0;
    busy_bad = 0;
    @(negedge clk);
    for (int w = 0; w < 100 && !blk_ready; w++) @(negedge clk);
    init      = with_init;
    blk_data  = data;
    blk_last  = last;
    blk_valid = 1'b1;
    @(negedge clk);
    blk_valid = 1'b0;
    init      = 1'b0;
    blk_last  = 1'($urandom);
    cnt = 1;
    while (cnt <= 120) begin
      if (digest_valid) dv_count++;
      if (blk_ready) begin
        lat = cnt;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
      if (scramble) blk_data = rand_blk();
      init = (cnt == init_step + 1);
      @(negedge clk);
      cnt++;
    end
    init = 1'b0;
    dg = digest;
  endtask

  initial begin
    logic [511:0] d_empty, d_abc, b1, b2, bb[3];
    logic [127:0] dg, chain, dg_bb;
    int lat, dvc, bbad, n, dvs, rbad, pending, dv_seen;
    int acc_cyc[3];

    // Reset block
    rst = 1'b1; init = 1'b0; blk_valid = 1'b0; blk_data = '0; blk_last = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_blk_ready", 128'(blk_ready), 128'd1);
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_digest_valid", 128'(digest_valid), 128'd0);
    check("reset_digest", digest, 128'd0);
    rst = 1'b0;

    // Vector table: single-block messages, each started with init
    d_empty = '0; d_empty[31:0] = 32'h00000080;
    d_abc = '0; d_abc[31:0] = 32'h80636261; d_abc[32*14 +: 32] = 32'h18;
    vec[0] = '{data: d_empty, exp: DG_EMPTY};
    vec[1] = '{data: d_abc, exp: DG_ABC};
    for (int i = 2; i < 6; i++) begin
      vec[i].data = rand_blk();
      vec[i].exp  = md4_model(IV_CHAIN, vec[i].data);
    end
    for (int i = 0; i < 6; i++) begin
      run_block(vec[i].data, 1'b1, 1'b1, -1, 1'b0, lat, dvc, bbad, dg);
      check($sformatf("vec%0d_latency", i), 128'(lat), 128'd50);
      check($sformatf("vec%0d_dv_count", i), 128'(dvc), 128'd1);
      check($sformatf("vec%0d_digest", i), dg, vec[i].exp);
      check($sformatf("vec%0d_busy", i), 128'(bbad), 128'd0);
    end
    // Pulse is one cycle wide and the digest holds
    @(negedge clk);
    check("dv_pulse_width", 128'(digest_valid), 128'd0);
    check("digest_hold", digest, vec[5].exp);

    // Two-block message: 56 x 'a'
    b1 = '0;
    for (int i = 0; i < 14; i++) b1[32*i +: 32] = 32'h61616161;
    b1[32*14 +: 32] = 32'h00000080;
    b2 = '0; b2[32*14 +: 32] = 32'h000001C0;
    run_block(b1, 1'b0, 1'b1, -1, 1'b0, lat, dvc, bbad, dg);
    check("two_blk1_latency", 128'(lat), 128'd50);
    check("two_blk1_no_pulse", 128'(dvc), 128'd0);
    check("two_blk1_digest_held", dg, vec[5].exp);
    run_block(b2, 1'b1, 1'b0, -1, 1'b0, lat, dvc, bbad, dg);
    check("two_blk2_dv_count", 128'(dvc), 128'd1);
    check("two_blk2_digest", dg, md4_model(md4_model(IV_CHAIN, b1), b2));

    // Back-to-back: blk_valid held high across three blocks
    @(negedge clk); init = 1'b1;
    @(negedge clk); init = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bb[i] = rand_blk();
      acc_cyc[i] = -1000;
    end
    n = 0; dvs = 0; rbad = 0; pending = 0; dg_bb = '0;
    blk_valid = 1'b1; blk_data = bb[0]; blk_last = 1'b0;
    for (int cyc = 0; cyc < 220; cyc++) begin
      if (pending != 0) begin
        pending = 0;
        if (n < 3) begin
          blk_data = bb[n];
          blk_last = (n == 2);
        end else begin
          blk_valid = 1'b0;
        end
      end
      if (digest_valid) begin
        dvs++;
        dg_bb = digest;
      end
      if (busy !== ~blk_ready) rbad++;
      if (blk_valid && blk_ready && n < 3) begin
        acc_cyc[n] = cyc;
        n++;
        pending = 1;
      end
      @(negedge clk);
    end
    blk_valid = 1'b0;
    check("b2b_accepted", 128'(n), 128'd3);
    check("b2b_gap01", 128'(acc_cyc[1] - acc_cyc[0]), 128'd50);
    check("b2b_gap12", 128'(acc_cyc[2] - acc_cyc[1]), 128'd50);
    check("b2b_busy_vs_ready", 128'(rbad), 128'd0);
    check("b2b_dv_count", 128'(dvs), 128'd1);
    chain = md4_model(md4_model(md4_model(IV_CHAIN, bb[0]), bb[1]), bb[2]);
    check("b2b_digest", dg_bb, chain);

    // "abc" with blk_data scrambled mid-block
    run_block(d_abc, 1'b1, 1'b1, -1, 1'b1, lat, dvc, bbad, dg);
    check("scramble_latency", 128'(lat), 128'd50);
    check("scramble_digest", dg, DG_ABC);

    // init pulsed at step 20 of the second block of a message is ignored
    b1 = rand_blk();
    b2 = rand_blk();
    run_block(b1, 1'b0, 1'b1, -1, 1'b0, lat, dvc, bbad, dg);
    run_block(b2, 1'b1, 1'b0, 20, 1'b1, lat, dvc, bbad, dg);
    check("midinit_dv_count", 128'(dvc), 128'd1);
    check("midinit_digest", dg, md4_model(md4_model(IV_CHAIN, b1), b2));

    // Reset at step 30: immediate abort, no digest_valid
    @(negedge clk);
    init = 1'b1; blk_data = d_abc; blk_last = 1'b1; blk_valid = 1'b1;
    @(negedge clk);
    init = 1'b0; blk_valid = 1'b0;
    repeat (30) @(negedge clk);
    check("rst_pre_busy", 128'(busy), 128'd1);
    rst = 1'b1;
    #1;
    check("rst_async_ready", 128'(blk_ready), 128'd1);
    check("rst_async_busy", 128'(busy), 128'd0);
    check("rst_async_dv", 128'(digest_valid), 128'd0);
    check("rst_async_digest", digest, 128'd0);
    dv_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (digest_valid) dv_seen++;
    end
    rst = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (digest_valid) dv_seen++;
    end
    check("rst_no_dv", 128'(dv_seen), 128'd0);
    run_block(d_abc, 1'b1, 1'b0, -1, 1'b0, lat, dvc, bbad, dg);
    check("rst_rerun_latency", 128'(lat), 128'd50);
    check("rst_rerun_digest", dg, DG_ABC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
